instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: decoder/EXE control, instruction memory port and ID-facing outputs.
// master = fetch unit, slave = surrounding pipeline and memory.
interface instr_fetch_if;
   localparam int unsigned XLEN = 32;

   logic            stall;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [XLEN-1:0] imem_rdata;
   logic [XLEN-1:0] instruction;
   logic            instr_valid;
   logic [XLEN-1:0] pc_out;
   logic            halted;

   modport master (
      input  stall, branch_taken, branch_target, imem_ready, imem_rdata,
      output imem_req, imem_addr, instruction, instr_valid, pc_out, halted
   );

   modport slave (
      output stall, branch_taken, branch_target, imem_ready, imem_rdata,
      input  imem_req, imem_addr, instruction, instr_valid, pc_out, halted
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC, single-bubble branch redirect, halt on HALT_INSTR.
// Outputs are registered except imem_req/imem_addr, which follow state and pc directly.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'hF000_0000,
   parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_fetch_if.master bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      REDIRECT = 2'd1,
      HALTED   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_out_q, pc_out_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            halted_q;
   logic            req_c;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         pc_out_q <= RESET_PC;
         instr_q  <= NOP_INSTR;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         halted_q <= (state_d == HALTED);
      end
   end

   // Next-state and next-output logic; branch wins over stall, ready and halt capture
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      req_c    = 1'b0;

      unique case (state_q)
         FETCH: begin
            req_c = !bus.stall;
            if (bus.branch_taken) begin
               pc_d    = bus.branch_target;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
               state_d = REDIRECT;
            end else if (!bus.stall) begin
               if (bus.imem_ready) begin
                  instr_d  = bus.imem_rdata;
                  pc_out_d = pc_q;
                  pc_d     = pc_q + XLEN'(4);
                  valid_d  = 1'b1;
                  if (bus.imem_rdata == HALT_INSTR) state_d = HALTED;
               end else begin
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
               end
            end
         end
         REDIRECT: begin
            if (bus.branch_taken) begin
               pc_d    = bus.branch_target;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end else begin
               state_d = FETCH;
            end
         end
         HALTED: begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
         default: state_d = FETCH;
      endcase
   end

   assign bus.imem_req    = req_c;
   assign bus.imem_addr   = pc_q;
   assign bus.instruction = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc_out      = pc_out_q;
   assign bus.halted      = halted_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic vs a stream model.
module tb_instr_fetch;
   localparam logic [31:0] RPC  = 32'h0000_0000;
   localparam logic [31:0] NOP  = 32'hF000_0000;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic ready = 1'b1;
   logic [31:0] mem [256];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch_if bus ();

   assign bus.imem_ready = ready;
   assign bus.imem_rdata = ready ? mem[bus.imem_addr[9:2]] : 32'hDEAD_BEEF;

   instr_fetch #(.RESET_PC(RPC), .NOP_INSTR(NOP), .HALT_INSTR(HALT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         if (mem[i] == HALT) mem[i] = 32'h0;
      end
   endtask

   task automatic do_reset();
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
      ready = 1'b1;
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
      fill_mem();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.instruction, bus.instr_valid, bus.pc_out, bus.halted, bus.imem_addr} !==
          {NOP, 1'b0, RPC, 1'b0, RPC}) begin
         n_fail++;
         $display("FAIL reset_async got instr=%h v=%b pc_out=%h h=%b addr=%h want %h 0 %h 0 %h",
                  bus.instruction, bus.instr_valid, bus.pc_out, bus.halted, bus.imem_addr, NOP, RPC, RPC);
      end
      step(); step();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, RPC}) begin
         n_fail++;
         $display("FAIL reset_first_req got req=%b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, RPC);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] words [3];
      words[0] = 32'h0000_FFFF; words[1] = 32'h0200_EEEE; words[2] = 32'h0640_0000;
      fill_mem();
      for (int i = 0; i < 3; i++) mem[i] = words[i];
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({bus.instruction, bus.instr_valid, bus.pc_out} !== {words[i], 1'b1, 32'(4 * i)}) begin
            n_fail++;
            $display("FAIL seq_%0d got %h v=%b pc_out=%h want %h 1 %h",
                     i, bus.instruction, bus.instr_valid, bus.pc_out, words[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_stall();
      fill_mem();
      mem[0] = 32'h2200_0001;
      do_reset();
      step();
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if ({bus.imem_req, bus.instruction, bus.instr_valid, bus.pc_out, bus.imem_addr} !==
             {1'b0, 32'h2200_0001, 1'b1, 32'h0, 32'h4}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d got req=%b %h v=%b pc_out=%h addr=%h want 0 22000001 1 0 4",
                     i, bus.imem_req, bus.instruction, bus.instr_valid, bus.pc_out, bus.imem_addr);
         end
         step();
      end
      bus.stall = 1'b0;
      step();
      n_checks++;
      if ({bus.instruction, bus.pc_out} !== {mem[1], 32'h4}) begin
         n_fail++;
         $display("FAIL stall_resume got %h pc_out=%h want %h 4", bus.instruction, bus.pc_out, mem[1]);
      end
   endtask

   task automatic test_branch();
      fill_mem();
      do_reset();
      step();
      bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0040; bus.stall = 1'b1;
      step();
      bus.branch_taken = 1'b0; bus.stall = 1'b0;
      #1;
      n_checks++;
      if ({bus.instruction, bus.instr_valid, bus.imem_req, bus.imem_addr} !== {NOP, 1'b0, 1'b0, 32'h40}) begin
         n_fail++;
         $display("FAIL branch_bubble got %h v=%b req=%b addr=%h want %h 0 0 40",
                  bus.instruction, bus.instr_valid, bus.imem_req, bus.imem_addr, NOP);
      end
      step();
      n_checks++;
      if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
         n_fail++;
         $display("FAIL branch_refetch got v=%b req=%b addr=%h want 0 1 40",
                  bus.instr_valid, bus.imem_req, bus.imem_addr);
      end
      step();
      n_checks++;
      if ({bus.instruction, bus.instr_valid, bus.pc_out} !== {mem[16], 1'b1, 32'h40}) begin
         n_fail++;
         $display("FAIL branch_target_word got %h v=%b pc_out=%h want %h 1 40",
                  bus.instruction, bus.instr_valid, bus.pc_out, mem[16]);
      end
      // redirect again while redirecting, to an unaligned target
      bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
      step();
      bus.branch_target = 32'h42;
      step();
      bus.branch_taken = 1'b0;
      #1;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h42}) begin
         n_fail++;
         $display("FAIL branch_rebranch got req=%b addr=%h want 0 42", bus.imem_req, bus.imem_addr);
      end
      step(); step();
      n_checks++;
      if ({bus.instruction, bus.pc_out, bus.imem_addr} !== {mem[16], 32'h42, 32'h46}) begin
         n_fail++;
         $display("FAIL branch_unaligned got %h pc_out=%h addr=%h want %h 42 46",
                  bus.instruction, bus.pc_out, bus.imem_addr, mem[16]);
      end
      // pc wraps modulo 2^32
      bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
      step();
      bus.branch_taken = 1'b0;
      step(); step();
      n_checks++;
      if ({bus.instruction, bus.pc_out, bus.imem_addr} !== {mem[255], 32'hFFFF_FFFC, 32'h0}) begin
         n_fail++;
         $display("FAIL branch_wrap got %h pc_out=%h addr=%h want %h fffffffc 0",
                  bus.instruction, bus.pc_out, bus.imem_addr, mem[255]);
      end
   endtask

   task automatic test_mem_wait();
      fill_mem();
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if ({bus.instr_valid, bus.instruction, bus.imem_addr} !== {1'b0, NOP, RPC}) begin
            n_fail++;
            $display("FAIL wait_%0d got v=%b %h addr=%h want 0 %h %h",
                     i, bus.instr_valid, bus.instruction, bus.imem_addr, NOP, RPC);
         end
      end
      ready = 1'b1;
      step();
      n_checks++;
      if ({bus.instruction, bus.instr_valid, bus.pc_out} !== {mem[0], 1'b1, RPC}) begin
         n_fail++;
         $display("FAIL wait_capture got %h v=%b pc_out=%h want %h 1 %h",
                  bus.instruction, bus.instr_valid, bus.pc_out, mem[0], RPC);
      end
   endtask

   task automatic test_branch_vs_halt();
      fill_mem();
      mem[0] = HALT;
      do_reset();
      bus.branch_taken = 1'b1; bus.branch_target = 32'h20;
      step();
      bus.branch_taken = 1'b0;
      n_checks++;
      if ({bus.halted, bus.instr_valid, bus.imem_addr} !== {1'b0, 1'b0, 32'h20}) begin
         n_fail++;
         $display("FAIL branch_beats_halt got h=%b v=%b addr=%h want 0 0 20",
                  bus.halted, bus.instr_valid, bus.imem_addr);
      end
      step(); step();
      n_checks++;
      if ({bus.halted, bus.instruction, bus.pc_out} !== {1'b0, mem[8], 32'h20}) begin
         n_fail++;
         $display("FAIL branch_beats_halt_fetch got h=%b %h pc_out=%h want 0 %h 20",
                  bus.halted, bus.instruction, bus.pc_out, mem[8]);
      end
   endtask

   task automatic test_halt();
      fill_mem();
      mem[3] = HALT;
      do_reset();
      step(); step(); step(); step();
      n_checks++;
      if ({bus.instruction, bus.instr_valid, bus.pc_out, bus.halted, bus.imem_req, bus.imem_addr} !==
          {HALT, 1'b1, 32'hC, 1'b1, 1'b0, 32'h10}) begin
         n_fail++;
         $display("FAIL halt_capture got %h v=%b pc_out=%h h=%b req=%b addr=%h want ffffffff 1 c 1 0 10",
                  bus.instruction, bus.instr_valid, bus.pc_out, bus.halted, bus.imem_req, bus.imem_addr);
      end
      bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
      for (int i = 0; i < 3; i++) begin
         bus.stall = i[0];
         step();
         n_checks++;
         if ({bus.instruction, bus.instr_valid, bus.halted, bus.imem_req, bus.imem_addr} !==
             {NOP, 1'b0, 1'b1, 1'b0, 32'h10}) begin
            n_fail++;
            $display("FAIL halt_stays_%0d got %h v=%b h=%b req=%b addr=%h want %h 0 1 0 10",
                     i, bus.instruction, bus.instr_valid, bus.halted, bus.imem_req, bus.imem_addr, NOP);
         end
      end
      bus.branch_taken = 1'b0; bus.stall = 1'b0;
   endtask

   task automatic test_async_reset();
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.instruction, bus.instr_valid, bus.pc_out, bus.halted, bus.imem_addr} !==
          {NOP, 1'b0, RPC, 1'b0, RPC}) begin
         n_fail++;
         $display("FAIL async_reset got %h v=%b pc_out=%h h=%b addr=%h want %h 0 %h 0 %h",
                  bus.instruction, bus.instr_valid, bus.pc_out, bus.halted, bus.imem_addr, NOP, RPC, RPC);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, RPC}) begin
         n_fail++;
         $display("FAIL async_restart_req got req=%b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, RPC);
      end
      step();
      n_checks++;
      if ({bus.instruction, bus.instr_valid, bus.pc_out, bus.halted} !== {mem[0], 1'b1, RPC, 1'b0}) begin
         n_fail++;
         $display("FAIL async_restart_fetch got %h v=%b pc_out=%h h=%b want %h 1 %h 0",
                  bus.instruction, bus.instr_valid, bus.pc_out, bus.halted, mem[0], RPC);
      end
   endtask

   // Randomized traffic against a model of the fetch stream: next address, one dead
   // cycle after each redirect, and the last presented word.
   task automatic test_random();
      logic [31:0] next_addr, exp_instr, exp_pc_out;
      logic        exp_valid, stl, br;
      int          dead;
      logic [31:0] tgt;
      fill_mem();
      do_reset();
      next_addr = RPC; exp_instr = NOP; exp_pc_out = RPC; exp_valid = 1'b0; dead = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         stl = ($urandom % 4) == 0;
         br  = ($urandom % 8) == 0;
         tgt = 32'($urandom_range(0, 1023));
         bus.stall = stl; bus.branch_taken = br; bus.branch_target = tgt;
         ready = ($urandom % 3) != 0;
         #1;
         n_checks++;
         if ({bus.imem_req, bus.imem_addr} !== {(dead == 0) && !stl, next_addr}) begin
            n_fail++;
            $display("FAIL rand_req_%0d got req=%b addr=%h want %b %h",
                     cyc, bus.imem_req, bus.imem_addr, (dead == 0) && !stl, next_addr);
         end
         if (br) begin
            next_addr = tgt; exp_instr = NOP; exp_valid = 1'b0; dead = 1;
         end else if (dead > 0) begin
            dead = 0;
         end else if (!stl) begin
            if (ready) begin
               exp_instr = mem[next_addr[9:2]]; exp_pc_out = next_addr;
               exp_valid = 1'b1; next_addr = next_addr + 32'd4;
            end else begin
               exp_instr = NOP; exp_valid = 1'b0;
            end
         end
         step();
         n_checks++;
         if ({bus.instruction, bus.instr_valid, bus.pc_out, bus.halted} !==
             {exp_instr, exp_valid, exp_pc_out, 1'b0}) begin
            n_fail++;
            $display("FAIL rand_out_%0d got %h v=%b pc_out=%h h=%b want %h %b %h 0",
                     cyc, bus.instruction, bus.instr_valid, bus.pc_out, bus.halted,
                     exp_instr, exp_valid, exp_pc_out);
         end
      end
      bus.stall = 1'b0; bus.branch_taken = 1'b0; ready = 1'b1;
   endtask

   initial begin
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_mem_wait();
      test_branch_vs_halt();
      test_halt();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
